// File: rtl/bmc_arbiter.sv
// Round-robin arbiter that collects decoded words from several bmc_decoder
// channels and presents them one at a time on a valid/ready output port.
module bmc_arbiter #(
    parameter int NB_CHANNELS    = 4,
    parameter int BIT_CONSIDERED = 17
) (
    input  logic                                 clk_96MHz,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [NB_CHANNELS-1:0]               dec_data_availible,
    input  logic [NB_CHANNELS*BIT_CONSIDERED-1:0] dec_decoded_data,
    input  logic [NB_CHANNELS*24-1:0]            dec_timestamp,
    output logic [NB_CHANNELS-1:0]               dec_enabled,
    output logic [NB_CHANNELS-1:0]               dec_reset,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [2:0]                           out_channel,
    output logic [BIT_CONSIDERED-1:0]            out_data,
    output logic [23:0]                          out_timestamp,
    output logic [15:0]                          words_sent
);

    typedef enum logic [1:0] {IDLE, CLEAR, OUTPUT} state_t;

    localparam logic [NB_CHANNELS-1:0] CH0_MASK = NB_CHANNELS'(1);

    state_t                    state;
    logic [2:0]                rr_ptr;
    logic                      grant_found;
    logic [2:0]                grant_idx;
    logic [2:0]                rr_next;
    logic [BIT_CONSIDERED-1:0] grant_data;
    logic [23:0]               grant_ts;

    // Two descending scans: the lowest requester at or above rr_ptr wins,
    // otherwise the lowest requester overall (the wrap-around case).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NB_CHANNELS - 1; i >= 0; i--) begin
            if (dec_data_availible[i] && (i >= int'(rr_ptr))) begin
                grant_found = 1'b1;
                grant_idx   = 3'(i);
            end
        end
        if (!grant_found) begin
            for (int i = NB_CHANNELS - 1; i >= 0; i--) begin
                if (dec_data_availible[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        grant_ts   = '0;
        for (int i = 0; i < NB_CHANNELS; i++) begin
            if (grant_idx == 3'(i)) begin
                grant_data = dec_decoded_data[i*BIT_CONSIDERED +: BIT_CONSIDERED];
                grant_ts   = dec_timestamp[i*24 +: 24];
            end
        end
    end

    assign rr_next = (grant_idx == 3'(NB_CHANNELS - 1)) ? 3'd0 : grant_idx + 3'd1;

    // dec_reset is a single-cycle pulse raised on the grant edge, so it is
    // high exactly while the FSM sits in CLEAR.
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_timestamp <= '0;
            out_channel   <= '0;
            words_sent    <= '0;
            dec_reset     <= '0;
            dec_enabled   <= '0;
        end else begin
            dec_enabled <= {NB_CHANNELS{enable}};
            dec_reset   <= '0;
            case (state)
                IDLE: begin
                    if (enable && grant_found) begin
                        out_channel   <= grant_idx;
                        out_data      <= grant_data;
                        out_timestamp <= grant_ts;
                        rr_ptr        <= rr_next;
                        dec_reset     <= CH0_MASK << grant_idx;
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    out_valid <= 1'b1;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        words_sent <= words_sent + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
